// File: rtl/watch_pkg.sv
// Shared definitions for the watch time/mode controller: mode encoding,
// BCD field limits, BCD digit type and the mode-sequencing helper.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_t;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEC_MAX  = 59;

  typedef logic [3:0] bcd_t;

  function automatic mode_t next_mode(input mode_t cur);
    mode_t nxt;
    case (cur)
      MODE_RUN:      nxt = MODE_SET_HOUR;
      MODE_SET_HOUR: nxt = MODE_SET_MIN;
      MODE_SET_MIN:  nxt = MODE_SET_SEC;
      default:       nxt = MODE_RUN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/watch_ctrl_bcd_pair_cnt.sv
// Two-digit BCD counter 00..MAX_VAL with increment, clear and a
// combinational carry-out on the increment that wraps back to 00.
module bcd_pair_cnt
  import watch_pkg::*;
#(
  parameter int MAX_VAL = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry
);

  localparam bcd_t MAX_TENS = bcd_t'(MAX_VAL / 10);
  localparam bcd_t MAX_ONES = bcd_t'(MAX_VAL % 10);

  bcd_t tens_reg;
  bcd_t ones_reg;
  logic at_max;

  assign at_max = (tens_reg == MAX_TENS) && (ones_reg == MAX_ONES);
  assign carry  = inc && at_max;
  assign tens   = tens_reg;
  assign ones   = ones_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tens_reg <= '0;
      ones_reg <= '0;
    end else if (clr) begin
      tens_reg <= '0;
      ones_reg <= '0;
    end else if (inc) begin
      if (at_max) begin
        tens_reg <= '0;
        ones_reg <= '0;
      end else if (ones_reg == 4'd9) begin
        tens_reg <= tens_reg + 4'd1;
        ones_reg <= '0;
      end else begin
        ones_reg <= ones_reg + 4'd1;
      end
    end
  end

endmodule

// File: rtl/watch_ctrl.sv
// Watch mode/timekeeping controller: one-second prescaler, HH:MM:SS BCD chain
// and the RUN/SET mode FSM. Blink divider is built only with WATCH_BLINK_EN.
module watch_ctrl
  import watch_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hour_10,
  output logic [3:0] hour1,
  output logic [3:0] min_10,
  output logic [3:0] min1,
  output logic [3:0] sec_10,
  output logic [3:0] sec1,
  output logic [1:0] mode,
  output logic       tick,
  output logic       blink
);

  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

  if ((CLK_HZ < 2) || (BLINK_HZ < 1) || ((CLK_HZ % (2 * BLINK_HZ)) != 0)) begin : g_bad_params
    $error("watch_ctrl: CLK_HZ must be >= 2 and divisible by 2*BLINK_HZ");
  end

  mode_t              mode_reg;
  mode_t              mode_next;
  logic [PRESC_W-1:0] presc_reg;
  logic               tick_reg;
  logic               advance;
  logic               set_hour_inc;
  logic               set_min_inc;
  logic               set_sec_clr;
  logic               sec_carry;
  logic               min_carry;
  logic               unused_hour_carry;
  logic               sec_inc;
  logic               min_inc;
  logic               hour_inc;

  always_ff @(posedge clk) begin
    if (!rst) mode_reg <= MODE_RUN;
    else      mode_reg <= mode_next;
  end

  // An increment pulse coinciding with a mode pulse is dropped.
  always_comb begin
    mode_next    = mode_reg;
    advance      = 1'b0;
    set_hour_inc = 1'b0;
    set_min_inc  = 1'b0;
    set_sec_clr  = 1'b0;
    if (btn_mode) mode_next = next_mode(mode_reg);
    case (mode_reg)
      MODE_RUN:      advance      = (presc_reg == PRESC_LAST);
      MODE_SET_HOUR: set_hour_inc = btn_inc && !btn_mode;
      MODE_SET_MIN:  set_min_inc  = btn_inc && !btn_mode;
      default:       set_sec_clr  = btn_inc && !btn_mode;
    endcase
  end

  // Any mode change or set mode discards the partial second.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_reg <= '0;
      tick_reg  <= 1'b0;
    end else begin
      tick_reg <= advance;
      if ((mode_reg != MODE_RUN) || btn_mode || advance) presc_reg <= '0;
      else                                              presc_reg <= presc_reg + 1'b1;
    end
  end

  assign sec_inc  = advance;
  assign min_inc  = (advance && sec_carry) || set_min_inc;
  assign hour_inc = (advance && min_carry) || set_hour_inc;

  bcd_pair_cnt #(.MAX_VAL(SEC_MAX)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .inc   (sec_inc),
    .clr   (set_sec_clr),
    .tens  (sec_10),
    .ones  (sec1),
    .carry (sec_carry)
  );

  bcd_pair_cnt #(.MAX_VAL(MIN_MAX)) u_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (min_inc),
    .clr   (1'b0),
    .tens  (min_10),
    .ones  (min1),
    .carry (min_carry)
  );

  bcd_pair_cnt #(.MAX_VAL(HOUR_MAX)) u_hour (
    .clk   (clk),
    .rst   (rst),
    .inc   (hour_inc),
    .clr   (1'b0),
    .tens  (hour_10),
    .ones  (hour1),
    .carry (unused_hour_carry)
  );

  assign mode = mode_reg;
  assign tick = tick_reg;

`ifdef WATCH_BLINK_EN
  localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [BLINK_W-1:0] blink_div_reg;
  logic               blink_reg;

  // Phase restarts on every mode change so each field starts visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_div_reg <= '0;
      blink_reg     <= 1'b0;
    end else if ((mode_reg == MODE_RUN) || btn_mode) begin
      blink_div_reg <= '0;
      blink_reg     <= 1'b0;
    end else if (blink_div_reg == BLINK_LAST) begin
      blink_div_reg <= '0;
      blink_reg     <= ~blink_reg;
    end else begin
      blink_div_reg <= blink_div_reg + 1'b1;
    end
  end

  assign blink = blink_reg;
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_watch_ctrl.sv
// Self-checking bench for watch_ctrl (CLK_HZ=4, BLINK_HZ=1; blink checks
// follow WATCH_BLINK_EN). Per-cycle scoreboard plus fixed-value scenario checks.
module tb_watch_ctrl;

  localparam int CLK_HZ   = 4;
  localparam int BLINK_HZ = 1;
  localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] hour_10, hour1, min_10, min1, sec_10, sec1;
  logic [1:0] mode;
  logic       tick;
  logic       blink;

  int checks = 0;
  int errors = 0;

  logic [27:0] exp_q[$];
  logic [27:0] obs_q[$];

  int m_h, m_m, m_s, m_md, m_presc, m_bdiv;
  bit m_tick, m_blink;

  watch_ctrl #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .hour_10  (hour_10),
    .hour1    (hour1),
    .min_10   (min_10),
    .min1     (min1),
    .sec_10   (sec_10),
    .sec1     (sec1),
    .mode     (mode),
    .tick     (tick),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] pack_exp();
    return {4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10),
            4'(m_s / 10), 4'(m_s % 10), 2'(m_md), m_tick, m_blink};
  endfunction

  function automatic logic [27:0] pack_obs();
    return {hour_10, hour1, min_10, min1, sec_10, sec1, mode, tick, blink};
  endfunction

  function automatic logic [23:0] time_obs();
    return {hour_10, hour1, min_10, min1, sec_10, sec1};
  endfunction

  task automatic model_step(input logic r, input logic bm, input logic bi);
    bit adv;
    if (!r) begin
      m_h = 0; m_m = 0; m_s = 0; m_md = 0; m_presc = 0;
      m_bdiv = 0; m_tick = 0; m_blink = 0;
      return;
    end
    adv = (m_md == 0) && (m_presc == CLK_HZ - 1);
`ifdef WATCH_BLINK_EN
    if (m_md == 0 || bm) begin
      m_bdiv = 0; m_blink = 0;
    end else if (m_bdiv == HALF - 1) begin
      m_bdiv = 0; m_blink = !m_blink;
    end else begin
      m_bdiv++;
    end
`endif
    if (m_md != 0 || bm || adv) m_presc = 0;
    else                        m_presc++;
    m_tick = adv;
    if (adv) begin
      m_s++;
      if (m_s == 60) begin
        m_s = 0; m_m++;
        if (m_m == 60) begin
          m_m = 0; m_h = (m_h + 1) % 24;
        end
      end
    end
    if (bi && !bm) begin
      case (m_md)
        1: m_h = (m_h + 1) % 24;
        2: m_m = (m_m + 1) % 60;
        3: m_s = 0;
        default: ;
      endcase
    end
    if (bm) m_md = (m_md + 1) % 4;
  endtask

  // Drive one cycle; expected pushed at drive time, observation after the edge.
  task automatic cyc(input logic r, input logic bm, input logic bi);
    rst = r; btn_mode = bm; btn_inc = bi;
    model_step(r, bm, bi);
    exp_q.push_back(pack_exp());
    if (!r || bm || bi)
      $display("t=%0t rst=%b btn_mode=%b btn_inc=%b -> expect %02d:%02d:%02d mode %0d",
               $time, r, bm, bi, m_h, m_m, m_s, m_md);
    @(posedge clk);
    #1;
    obs_q.push_back(pack_obs());
    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic press_mode(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    logic [27:0] e, o;
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (pack_obs() !== 28'h0) begin
      $display("FAIL reset_state got %h want %h", pack_obs(), 28'h0);
      errors++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin $display("FAIL reset_sb got %h want %h", o, e); errors++; end
    end
  endtask

  task automatic test_run();
    logic [27:0] e, o;
    int ticks = 0;
    for (int c = 1; c <= 40; c++) begin
      run(1);
      if (tick === 1'b1) ticks++;
      if (c == 3 || c == 4) begin
        checks++;
        if (sec1 !== ((c == 4) ? 4'd1 : 4'd0) || tick !== (c == 4)) begin
          $display("FAIL first_advance cycle %0d got sec1=%0d tick=%b", c, sec1, tick);
          errors++;
        end
      end
    end
    checks++;
    if (time_obs() !== 24'h000010) begin
      $display("FAIL run_40 got %h want 000010", time_obs()); errors++;
    end
    checks++;
    if (ticks != 10) begin $display("FAIL tick_count got %0d want 10", ticks); errors++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin $display("FAIL run_sb got %h want %h", o, e); errors++; end
    end
  endtask

  task automatic test_wrap();
    logic [27:0] e, o;
    int ticks = 0;
    press_mode(1); press_inc(23);
    press_mode(1); press_inc(59);
    press_mode(1); press_inc(1);
    press_mode(1);
    run(59 * CLK_HZ);
    checks++;
    if (time_obs() !== 24'h235959) begin
      $display("FAIL preload got %h want 235959", time_obs()); errors++;
    end
    for (int c = 0; c < CLK_HZ; c++) begin
      run(1);
      if (tick === 1'b1) ticks++;
    end
    checks++;
    if (time_obs() !== 24'h000000 || ticks != 1) begin
      $display("FAIL midnight_wrap got %h ticks %0d want 000000 ticks 1", time_obs(), ticks);
      errors++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin $display("FAIL wrap_sb got %h want %h", o, e); errors++; end
    end
  endtask

  task automatic test_set_min_hour();
    logic [27:0] e, o;
    press_mode(1); press_inc(12);
    press_mode(1); press_inc(59);
    press_mode(1); press_inc(1);
    press_mode(1);
    run(30 * CLK_HZ);
    press_mode(2); press_inc(1);
    checks++;
    if (time_obs() !== 24'h120030 || mode !== 2'd2) begin
      $display("FAIL set_min_wrap got %h mode %0d want 120030 mode 2", time_obs(), mode);
      errors++;
    end
    press_mode(3); press_inc(11);
    checks++;
    if (time_obs() !== 24'h230030) begin
      $display("FAIL set_hour_23 got %h want 230030", time_obs()); errors++;
    end
    press_inc(1);
    checks++;
    if (time_obs() !== 24'h000030 || mode !== 2'd1) begin
      $display("FAIL set_hour_wrap got %h mode %0d want 000030 mode 1", time_obs(), mode);
      errors++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin $display("FAIL setmh_sb got %h want %h", o, e); errors++; end
    end
  endtask

  task automatic test_set_sec();
    logic [27:0] e, o;
    logic [3:0] tk;
    press_inc(5);
    press_mode(1); press_inc(6);
    press_mode(1); press_inc(1);
    press_mode(1);
    run(47 * CLK_HZ);
    press_mode(3);
    checks++;
    if (time_obs() !== 24'h050647 || mode !== 2'd3) begin
      $display("FAIL pre_set_sec got %h mode %0d want 050647 mode 3", time_obs(), mode);
      errors++;
    end
    press_inc(1);
    checks++;
    if (time_obs() !== 24'h050600) begin
      $display("FAIL set_sec_clear got %h want 050600", time_obs()); errors++;
    end
    press_mode(1);
    for (int c = 0; c < CLK_HZ; c++) begin
      run(1);
      tk[c] = tick;
    end
    checks++;
    if (tk !== 4'b1000 || time_obs() !== 24'h050601) begin
      $display("FAIL restart_prescaler got ticks %b time %h want 1000 050601", tk, time_obs());
      errors++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin $display("FAIL setsec_sb got %h want %h", o, e); errors++; end
    end
  endtask

  task automatic test_same_cycle();
    logic [27:0] e, o;
    press_mode(1); press_inc(5);
    cyc(1'b1, 1'b1, 1'b1);
    checks++;
    if (mode !== 2'd2 || hour_10 !== 4'd1 || hour1 !== 4'd0) begin
      $display("FAIL mode_and_inc got mode %0d hour %0d%0d want mode 2 hour 10", mode, hour_10, hour1);
      errors++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin $display("FAIL same_sb got %h want %h", o, e); errors++; end
    end
  endtask

  task automatic test_reset_mid_set();
    logic [27:0] e, o;
    press_mode(1); press_inc(1);
    press_mode(2); press_inc(21);
    press_mode(1); press_inc(24);
    press_mode(2);
    run(15 * CLK_HZ);
    press_mode(2);
    checks++;
    if (time_obs() !== 24'h073015 || mode !== 2'd2) begin
      $display("FAIL pre_reset got %h mode %0d want 073015 mode 2", time_obs(), mode);
      errors++;
    end
    cyc(1'b0, 1'b0, 1'b1);
    checks++;
    if (pack_obs() !== 28'h0) begin
      $display("FAIL reset_mid_set got %h want 0", pack_obs()); errors++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin $display("FAIL rstmid_sb got %h want %h", o, e); errors++; end
    end
  endtask

  task automatic test_blink();
    logic [27:0] e, o;
    logic [7:0] bv;
    logic [7:0] bv_exp;
    int highs = 0;
`ifdef WATCH_BLINK_EN
    bv_exp = 8'b0110_0110;
`else
    bv_exp = 8'b0000_0000;
`endif
    press_mode(1);
    for (int c = 0; c < 8; c++) begin
      run(1);
      bv[c] = blink;
    end
    checks++;
    if (bv !== bv_exp) begin
      $display("FAIL blink_pattern got %b want %b", bv, bv_exp); errors++;
    end
    run(1);
    press_mode(1);
    checks++;
    if (blink !== 1'b0 || mode !== 2'd2) begin
      $display("FAIL blink_restart got blink %b mode %0d want 0 mode 2", blink, mode); errors++;
    end
    press_mode(2);
    for (int c = 0; c < 8; c++) begin
      run(1);
      if (blink !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin $display("FAIL blink_in_run got %0d highs want 0", highs); errors++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin $display("FAIL blink_sb got %h want %h", o, e); errors++; end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_wrap();
    test_set_min_hour();
    test_set_sec();
    test_same_cycle();
    test_reset_mid_set();
    test_blink();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
